mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the shared instruction/data memory port driven by the fetch/decode memory arbiter.
- Accepts one read or write request at a time and services it after a programmable latency.
- Handshakes back with one-cycle `mem_output_valid_out` (read) or `mem_write_ready_out` (write) pulses.
- Backed by a word-organised, little-endian internal array; supports halfword (instruction fetch) and word (decoder load/store) accesses.

Parameters:
- ADDR_W, 12, byte-address width; array depth = 2^(ADDR_W-2) 32-bit words
- READ_LATENCY, 2, cycles from request acceptance to `mem_output_valid_out` (legal 1..15)
- WRITE_LATENCY, 1, cycles from request acceptance to `mem_write_ready_out` (legal 1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- addr_in  in  ADDR_W  byte address of request
- read_en_in  in  1  read request, held by requester until `mem_output_valid_out`
- write_en_in  in  1  write request, held by requester until `mem_write_ready_out`
- word_select_in  in  1  1 = halfword access, 0 = word access
- data_in  in  32  write data; halfword writes use [15:0]
- data_out  out  32  read data; halfword reads zero-extended
- mem_output_valid_out  out  1  one-cycle pulse, `data_out` valid this cycle
- mem_write_ready_out  out  1  one-cycle pulse, write committed at this cycle's edge
- busy_out  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - `reset` is synchronous and active-high.
  - On reset: state=IDLE, counter=0, `data_out`=0, `mem_output_valid_out`=0, `mem_write_ready_out`=0, `busy_out`=0.
  - Array contents are not cleared by reset.
- States:
  - IDLE: if `write_en_in`, go to WRITE_WAIT. Else if `read_en_in`, go to READ_WAIT. Else stay in IDLE.
  - Simultaneous `read_en_in` and `write_en_in`: write wins; the read is ignored and the requester re-presents it later.
  - On acceptance, latch `addr_in`, `data_in` and `word_select_in` and load counter = latency-1. Later changes to these inputs are ignored until the next acceptance.
  - READ_WAIT: decrement counter each cycle. In the cycle counter==0:
    - assert `mem_output_valid_out` for exactly one cycle;
    - present the read data on `data_out` in that same cycle;
    - go to IDLE on the following edge.
  - WRITE_WAIT: decrement counter each cycle. In the cycle counter==0:
    - assert `mem_write_ready_out` for exactly one cycle;
    - commit the array write on that edge;
    - go to IDLE.
- Latency:
  - READ_LATENCY=1 gives valid in the cycle after acceptance.
  - Latency N gives valid N cycles after the acceptance cycle. Writes behave the same way.
- Back-to-back requests:
  - IDLE always lasts at least one cycle between requests.
  - A request still asserted in the IDLE cycle after a valid/ready pulse is accepted as a new request.
  - Requesters must drop request lines in the pulse cycle if no new access is wanted.
- Addressing:
  - word index = addr[ADDR_W-1:2].
  - Word access ignores addr[1:0].
  - Halfword access: addr[1]=0 selects bits [15:0], addr[1]=1 selects bits [31:16]; addr[0] is ignored.
- Halfword write: modifies only the selected 16 bits; the other half of the word is preserved.
- `data_out` holds its last read value until the next read completes. Write completions do not change it.
- Reset mid-operation: the pending access is aborted. A write not yet acknowledged is not committed, and no valid/ready pulse is produced.
- Address wrap: the top address maps to the last word; there is no out-of-range handling.

Optional Feature:
- Macro `MEM_RESP_ALIGN_ERR_EN`.
- When defined:
  - adds output `align_err_out` (1 bit, reset 0);
  - misalignment is addr[0]=1 for halfword accesses, or addr[1:0]!=0 for word accesses;
  - on a misaligned access, `align_err_out` pulses together with the valid/ready pulse of that access;
  - a misaligned write is suppressed (array unchanged), but `mem_write_ready_out` still pulses;
  - a misaligned read returns 0 on `data_out`.
- When undefined: no `align_err_out` port; low address bits are silently ignored as described above.

Test Plan:
- Reset, then word write 0xDEADBEEF at addr 0x010 (WRITE_LATENCY=1) -> `mem_write_ready_out` high exactly 1 cycle after acceptance. Then word read 0x010 (READ_LATENCY=2) -> valid 2 cycles after acceptance with `data_out`=0xDEADBEEF, `busy_out` high for 2 cycles.
- Halfword write 0x1234 to 0x012 over word 0xDEADBEEF at 0x010 -> word read 0x010 returns 0x1234BEEF. Halfword read 0x010 returns 0x0000BEEF.
- `read_en_in` and `write_en_in` both asserted at addr 0x020 with data 0xA5A5A5A5 -> write accepted, only `mem_write_ready_out` pulses. Subsequent read of 0x020 returns 0xA5A5A5A5.
- Read held continuously for three accesses -> valid pulses spaced READ_LATENCY+1 cycles apart. Changing `addr_in` mid-wait does not change the returned data.
- Reset asserted in WRITE_WAIT before ready (WRITE_LATENCY=3, write 0x55 to 0x030, prior content 0x0) -> no ready pulse, all outputs 0 next cycle, read of 0x030 returns 0x00000000.
- With `MEM_RESP_ALIGN_ERR_EN`: word write to 0x032 -> ready and `align_err_out` pulse together, array unchanged. Halfword read 0x011 -> `data_out`=0, `align_err_out`=1 with valid.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bus between the fetch/decode memory arbiter (master) and mem_responder (slave).
// The align_err_out signal exists only when MEM_RESP_ALIGN_ERR_EN is defined.
interface mem_responder_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] addr_in;
    logic              read_en_in;
    logic              write_en_in;
    logic              word_select_in;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic              mem_output_valid_out;
    logic              mem_write_ready_out;
    logic              busy_out;
`ifdef MEM_RESP_ALIGN_ERR_EN
    logic              align_err_out;

    modport master (
        output addr_in, read_en_in, write_en_in, word_select_in, data_in,
        input  data_out, mem_output_valid_out, mem_write_ready_out, busy_out, align_err_out
    );
    modport slave (
        input  addr_in, read_en_in, write_en_in, word_select_in, data_in,
        output data_out, mem_output_valid_out, mem_write_ready_out, busy_out, align_err_out
    );
`else
    modport master (
        output addr_in, read_en_in, write_en_in, word_select_in, data_in,
        input  data_out, mem_output_valid_out, mem_write_ready_out, busy_out
    );
    modport slave (
        input  addr_in, read_en_in, write_en_in, word_select_in, data_in,
        output data_out, mem_output_valid_out, mem_write_ready_out, busy_out
    );
`endif
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with programmable read/write latency over a word array.
// Optional alignment checking is enabled by defining MEM_RESP_ALIGN_ERR_EN.
module mem_responder #(
    parameter int ADDR_W        = 12,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hw_q, hw_d;
    logic [31:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [31:0]       rd_word;
    logic [31:0]       rd_sel;
    logic              wr_commit;

    // NOTE: the array has no reset; contents survive reset and start undefined.
    logic [31:0]       mem [DEPTH];

`ifdef MEM_RESP_ALIGN_ERR_EN
    logic              align_err_q, align_err_d;
    logic              mis_d, mis_q;
`else
    logic              unused_addr_lsb;
    assign unused_addr_lsb = addr_q[0];
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hw_d    = hw_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (bus.write_en_in) begin
                    state_d = WRITE_WAIT;
                    cnt_d   = 4'(WRITE_LATENCY - 1);
                    addr_d  = bus.addr_in;
                    wdata_d = bus.data_in;
                    hw_d    = bus.word_select_in;
                end else if (bus.read_en_in) begin
                    state_d = READ_WAIT;
                    cnt_d   = 4'(READ_LATENCY - 1);
                    addr_d  = bus.addr_in;
                    wdata_d = bus.data_in;
                    hw_d    = bus.word_select_in;
                end
            end
            READ_WAIT, WRITE_WAIT: begin
                if (cnt_q == 4'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered: decode the state we are about to enter.
        valid_d = (state_d == READ_WAIT)  && (cnt_d == 4'd0);
        ready_d = (state_d == WRITE_WAIT) && (cnt_d == 4'd0);
        busy_d  = (state_d != IDLE);

        rd_word = mem[addr_d[ADDR_W-1:2]];
        if (hw_d) rd_sel = addr_d[1] ? {16'h0000, rd_word[31:16]} : {16'h0000, rd_word[15:0]};
        else      rd_sel = rd_word;

`ifdef MEM_RESP_ALIGN_ERR_EN
        mis_d       = hw_d ? addr_d[0] : (addr_d[1:0] != 2'b00);
        align_err_d = (valid_d || ready_d) && mis_d;
        if (valid_d) data_d = mis_d ? 32'h0 : rd_sel;
`else
        if (valid_d) data_d = rd_sel;
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            hw_q    <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MEM_RESP_ALIGN_ERR_EN
            align_err_q <= 1'b0;
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hw_q    <= hw_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
`ifdef MEM_RESP_ALIGN_ERR_EN
            align_err_q <= align_err_d;
            mis_q       <= mis_d;
`endif
        end
    end

    // The write lands on the edge that closes the ready-pulse cycle.
`ifdef MEM_RESP_ALIGN_ERR_EN
    assign wr_commit = (state_q == WRITE_WAIT) && (cnt_q == 4'd0) && !mis_q;
`else
    assign wr_commit = (state_q == WRITE_WAIT) && (cnt_q == 4'd0);
`endif

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            if (!hw_q)          mem[addr_q[ADDR_W-1:2]]        <= wdata_q;
            else if (addr_q[1]) mem[addr_q[ADDR_W-1:2]][31:16] <= wdata_q[15:0];
            else                mem[addr_q[ADDR_W-1:2]][15:0]  <= wdata_q[15:0];
        end
    end

    assign bus.data_out             = data_q;
    assign bus.mem_output_valid_out = valid_q;
    assign bus.mem_write_ready_out  = ready_q;
    assign bus.busy_out             = busy_q;
`ifdef MEM_RESP_ALIGN_ERR_EN
    assign bus.align_err_out        = align_err_q;
`endif
endmodule
